// File: rtl/morse_msg_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : morse_msg_sequencer
// Description : Buffers UART bytes in a circular FIFO, commits a message on
//               CR, and plays committed characters to a Morse generator over
//               a start/done handshake with letter/word gaps in programmable
//               units. Supports backspace editing, overflow detection and
//               receive during playback.
//               Optional macro MORSE_ABORT_EN adds the i_Abort input.
// Revision    : 1.0 - initial release
// ============================================================================
module morse_msg_sequencer #(
  parameter int DEPTH            = 256,
  parameter int UNIT_W           = 32,
  parameter int LETTER_GAP_UNITS = 2,
  parameter int WORD_GAP_UNITS   = 7
) (
  input  logic                   i_Clk,
  input  logic                   i_Rst,
  input  logic [UNIT_W-1:0]      i_Unit_Cycles,
  input  logic                   i_RX_DV,
  input  logic [7:0]             i_RX_Byte,
  output logic                   o_Echo_DV,
  output logic [7:0]             o_Echo_Byte,
  output logic                   o_Char_Start,
  output logic [7:0]             o_Char,
  input  logic                   i_Char_Done,
  output logic                   o_Busy,
  output logic                   o_Overflow,
`ifdef MORSE_ABORT_EN
  input  logic                   i_Abort,
`endif
  output logic [$clog2(DEPTH):0] o_Count
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam logic [7:0] CHAR_CR    = 8'h0D;
  localparam logic [7:0] CHAR_BS    = 8'h08;
  localparam logic [7:0] CHAR_DEL   = 8'h7F;
  localparam logic [7:0] CHAR_SPACE = 8'h20;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_START = 3'd2,
    S_WAIT  = 3'd3,
    S_GAP   = 3'd4
  } state_t;

  state_t            state, state_nxt;
  logic [PW-1:0]     wr_ptr, cm_ptr, rd_ptr;
  logic [PW-1:0]     count;
  logic [7:0]        mem [DEPTH];
  logic [7:0]        rd_byte;
  logic              full, is_cr, is_bs, is_data, abort;
  logic              char_start, load_char, gap_load, advance;
  logic [7:0]        gap_len_nxt, gap_len, gap_cnt;
  logic [UNIT_W-1:0] unit_len, unit_cnt;

`ifdef MORSE_ABORT_EN
  assign abort = i_Abort;
`else
  assign abort = 1'b0;
`endif

  // Pointers wrap modulo 2*DEPTH so a full buffer is distinguishable from empty.
  assign count   = wr_ptr - rd_ptr;
  assign full    = (count == PW'(DEPTH));
  assign rd_byte = mem[rd_ptr[AW-1:0]];
  assign is_cr   = (i_RX_Byte == CHAR_CR);
  assign is_bs   = (i_RX_Byte == CHAR_BS) || (i_RX_Byte == CHAR_DEL);
  assign is_data = !is_cr && !is_bs;

  // Receive path: write/commit/backspace pointer updates, echo and overflow flag.
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      wr_ptr      <= '0;
      cm_ptr      <= '0;
      o_Echo_DV   <= 1'b0;
      o_Echo_Byte <= 8'h00;
      o_Overflow  <= 1'b0;
    end else begin
      o_Echo_DV <= 1'b0;
      if (abort) begin
        cm_ptr <= wr_ptr;
      end else if (i_RX_DV) begin
        if (is_cr) begin
          cm_ptr      <= wr_ptr;
          o_Echo_DV   <= 1'b1;
          o_Echo_Byte <= CHAR_CR;
        end else if (is_bs) begin
          // Only uncommitted characters may be erased.
          if (wr_ptr != cm_ptr) begin
            wr_ptr      <= wr_ptr - PW'(1);
            o_Echo_DV   <= 1'b1;
            o_Echo_Byte <= CHAR_BS;
          end
        end else if (!full) begin
          wr_ptr      <= wr_ptr + PW'(1);
          o_Echo_DV   <= 1'b1;
          o_Echo_Byte <= i_RX_Byte;
        end else begin
          o_Overflow <= 1'b1;
        end
      end
    end
  end

  // Character storage; contents need no reset since pointers define validity.
  always_ff @(posedge i_Clk) begin
    if (!i_Rst && !abort && i_RX_DV && is_data && !full) begin
      mem[wr_ptr[AW-1:0]] <= i_RX_Byte;
    end
  end

  // Playback state register.
  always_ff @(posedge i_Clk) begin
    if (i_Rst) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Playback next-state and control strobes.
  always_comb begin
    state_nxt   = state;
    char_start  = 1'b0;
    load_char   = 1'b0;
    gap_load    = 1'b0;
    gap_len_nxt = 8'(LETTER_GAP_UNITS);
    advance     = 1'b0;
    case (state)
      S_IDLE: begin
        if (rd_ptr != cm_ptr) state_nxt = S_FETCH;
      end
      S_FETCH: begin
        load_char = 1'b1;
        if (rd_byte == CHAR_SPACE) begin
          gap_load    = 1'b1;
          gap_len_nxt = 8'(WORD_GAP_UNITS);
          state_nxt   = S_GAP;
        end else begin
          state_nxt = S_START;
        end
      end
      S_START: begin
        char_start = 1'b1;
        state_nxt  = S_WAIT;
      end
      S_WAIT: begin
        if (i_Char_Done) begin
          gap_load  = 1'b1;
          state_nxt = S_GAP;
        end
      end
      S_GAP: begin
        if ((unit_cnt == unit_len) && (gap_cnt >= gap_len)) begin
          advance   = 1'b1;
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
    if (abort) begin
      state_nxt  = S_IDLE;
      char_start = 1'b0;
      load_char  = 1'b0;
      gap_load   = 1'b0;
      advance    = 1'b0;
    end
  end

  // Playback datapath: read pointer, latched character and gap timing counters.
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      rd_ptr   <= '0;
      o_Char   <= 8'h00;
      gap_len  <= 8'h00;
      gap_cnt  <= 8'h00;
      unit_len <= UNIT_W'(1);
      unit_cnt <= '0;
    end else begin
      if (abort)        rd_ptr <= wr_ptr;
      else if (advance) rd_ptr <= rd_ptr + PW'(1);
      if (load_char) o_Char <= rd_byte;
      if (gap_load) begin
        // Unit length is sampled once at gap entry; zero means one cycle.
        gap_len  <= gap_len_nxt;
        gap_cnt  <= 8'd1;
        unit_cnt <= UNIT_W'(1);
        unit_len <= (i_Unit_Cycles == '0) ? UNIT_W'(1) : i_Unit_Cycles;
      end else if (state == S_GAP && !advance && !abort) begin
        if (unit_cnt == unit_len) begin
          unit_cnt <= UNIT_W'(1);
          gap_cnt  <= gap_cnt + 8'd1;
        end else begin
          unit_cnt <= unit_cnt + UNIT_W'(1);
        end
      end
    end
  end

  assign o_Char_Start = char_start;
  assign o_Busy       = (state != S_IDLE);
  assign o_Count      = count;

endmodule
`default_nettype wire

// File: tb/tb_morse_msg_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_morse_msg_sequencer
// Description : Directed self-checking bench for morse_msg_sequencer
//               (DEPTH=4). Covers MORSE_ABORT_EN when that macro is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_morse_msg_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] unit_cycles;
  logic        rx_dv;
  logic [7:0]  rx_byte;
  logic        echo_dv;
  logic [7:0]  echo_byte;
  logic        char_start;
  logic [7:0]  char_out;
  logic        char_done;
  logic        busy;
  logic        overflow;
  logic [2:0]  count;
`ifdef MORSE_ABORT_EN
  logic        abort;
`endif

  int tests = 0;
  int fails = 0;
  int n;
  bit found;

  always #5 clk = ~clk;

  morse_msg_sequencer #(
    .DEPTH(4), .UNIT_W(32), .LETTER_GAP_UNITS(2), .WORD_GAP_UNITS(7)
  ) dut (
    .i_Clk(clk), .i_Rst(rst), .i_Unit_Cycles(unit_cycles),
    .i_RX_DV(rx_dv), .i_RX_Byte(rx_byte),
    .o_Echo_DV(echo_dv), .o_Echo_Byte(echo_byte),
    .o_Char_Start(char_start), .o_Char(char_out), .i_Char_Done(char_done),
    .o_Busy(busy), .o_Overflow(overflow),
`ifdef MORSE_ABORT_EN
    .i_Abort(abort),
`endif
    .o_Count(count)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b, input logic exp_echo, input logic [7:0] exp_byte);
    rx_dv = 1'b1; rx_byte = b;
    tick;
    rx_dv = 1'b0; rx_byte = 8'h00;
    check("echo_dv", {31'd0, echo_dv}, {31'd0, exp_echo});
    if (exp_echo) check("echo_byte", {24'd0, echo_byte}, {24'd0, exp_byte});
  endtask

  task automatic wait_start(input int max, output int cnt, output bit hit);
    cnt = 0; hit = 1'b0;
    while (!hit && cnt < max) begin
      if (char_start) hit = 1'b1;
      else begin tick; cnt++; end
    end
  endtask

  task automatic wait_idle(input int max, output int cnt, output bit hit);
    cnt = 0; hit = 1'b0;
    while (!hit && cnt < max) begin
      if (!busy) hit = 1'b1;
      else begin tick; cnt++; end
    end
  endtask

  task automatic pulse_done;
    char_done = 1'b1;
    tick;
    char_done = 1'b0;
  endtask

  // Wait for a start, check its delay and character, then complete it.
  task automatic play(input logic [7:0] exp_char, input int exp_wait);
    int c; bit h;
    wait_start(100, c, h);
    check("start_seen", {31'd0, h}, 32'd1);
    check("start_delay", c, exp_wait);
    check("char", {24'd0, char_out}, {24'd0, exp_char});
    tick;
    check("start_one_cycle", {31'd0, char_start}, 32'd0);
    pulse_done;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; unit_cycles = 32'd4; rx_dv = 1'b0; rx_byte = 8'h00; char_done = 1'b0;
`ifdef MORSE_ABORT_EN
    abort = 1'b0;
`endif
    tick; tick;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_count", {29'd0, count}, 32'd0);
    check("rst_echo", {31'd0, echo_dv}, 32'd0);
    check("rst_char", {24'd0, char_out}, 32'd0);
    check("rst_ovf", {31'd0, overflow}, 32'd0);
    rst = 1'b0;
    tick;

    // SOS at U=4: start at T+3, 10 cycles from done sample to next start.
    send("S", 1'b1, "S");
    send("O", 1'b1, "O");
    send("S", 1'b1, "S");
    check("sos_count", {29'd0, count}, 32'd3);
    check("sos_uncommitted_idle", {31'd0, busy}, 32'd0);
    send(8'h0D, 1'b1, 8'h0D);
    check("sos_t1_idle", {31'd0, busy}, 32'd0);
    tick;
    check("sos_t2_nostart", {31'd0, char_start}, 32'd0);
    check("sos_t2_busy", {31'd0, busy}, 32'd1);
    tick;
    check("sos_t3_start", {31'd0, char_start}, 32'd1);
    check("sos_t3_char", {24'd0, char_out}, 32'h53);
    tick;
    pulse_done;
    play("O", 10);
    play("S", 10);
    wait_idle(50, n, found);
    check("sos_idle_seen", {31'd0, found}, 32'd1);
    check("sos_idle_delay", n, 32'd8);
    check("sos_count_end", {29'd0, count}, 32'd0);

    // Word gap: E, 8 letter-gap, IDLE, FETCH(space), 28 word-gap, IDLE, FETCH, START.
    send("E", 1'b1, "E");
    send(" ", 1'b1, " ");
    send("E", 1'b1, "E");
    send(8'h0D, 1'b1, 8'h0D);
    play("E", 2);
    play("E", 40);
    wait_idle(50, n, found);
    check("word_idle_delay", n, 32'd8);

    // Backspace editing.
    send(8'h08, 1'b0, 8'h00);
    send("A", 1'b1, "A");
    send("B", 1'b1, "B");
    send(8'h08, 1'b1, 8'h08);
    send("C", 1'b1, "C");
    check("bs_count", {29'd0, count}, 32'd2);
    send(8'h0D, 1'b1, 8'h0D);
    send(8'h7F, 1'b0, 8'h00);
    play("A", 1);
    play("C", 10);
    wait_idle(50, n, found);
    check("bs_idle_delay", n, 32'd8);

    // Overflow at DEPTH=4 (pointers have already wrapped past 2*DEPTH).
    check("ovf_before", {31'd0, overflow}, 32'd0);
    send("V", 1'b1, "V");
    send("W", 1'b1, "W");
    send("X", 1'b1, "X");
    send("Y", 1'b1, "Y");
    send("Z", 1'b0, 8'h00);
    check("ovf_count", {29'd0, count}, 32'd4);
    check("ovf_flag", {31'd0, overflow}, 32'd1);
    send(8'h0D, 1'b1, 8'h0D);
    play("V", 2);
    play("W", 10);
    play("X", 10);
    play("Y", 10);
    wait_idle(50, n, found);
    check("ovf_idle_delay", n, 32'd8);
    check("ovf_count_end", {29'd0, count}, 32'd0);
    check("ovf_sticky", {31'd0, overflow}, 32'd1);

    // Reset clears the sticky flag; then concurrent receive at U=1.
    rst = 1'b1; tick; rst = 1'b0;
    check("rst2_ovf", {31'd0, overflow}, 32'd0);
    unit_cycles = 32'd0;
    send("A", 1'b1, "A");
    send("B", 1'b1, "B");
    send("C", 1'b1, "C");
    send(8'h0D, 1'b1, 8'h0D);
    wait_start(20, n, found);
    check("cc_a_delay", n, 32'd2);
    check("cc_a_char", {24'd0, char_out}, 32'h41);
    send("D", 1'b1, "D");
    check("cc_count_full", {29'd0, count}, 32'd4);
    pulse_done;
    wait_start(20, n, found);
    check("cc_b_delay", n, 32'd4);
    check("cc_b_char", {24'd0, char_out}, 32'h42);
    send("E", 1'b1, "E");
    pulse_done;
    wait_start(20, n, found);
    check("cc_c_char", {24'd0, char_out}, 32'h43);
    send("F", 1'b1, "F");
    send(8'h0D, 1'b1, 8'h0D);
    pulse_done;
    play("D", 4);
    play("E", 4);
    play("F", 4);
    wait_idle(50, n, found);
    check("cc_idle_delay", n, 32'd2);
    check("cc_ovf", {31'd0, overflow}, 32'd0);
    check("cc_count_end", {29'd0, count}, 32'd0);

    // Reset while waiting for done.
    unit_cycles = 32'd1;
    send("K", 1'b1, "K");
    send(8'h0D, 1'b1, 8'h0D);
    wait_start(20, n, found);
    check("rw_start", {31'd0, found}, 32'd1);
    tick;
    rst = 1'b1; tick; rst = 1'b0;
    check("rw_busy", {31'd0, busy}, 32'd0);
    check("rw_count", {29'd0, count}, 32'd0);
    check("rw_char", {24'd0, char_out}, 32'd0);
    check("rw_start_low", {31'd0, char_start}, 32'd0);
    pulse_done;
    wait_start(20, n, found);
    check("rw_no_start", {31'd0, found}, 32'd0);

`ifdef MORSE_ABORT_EN
    // Abort during WAIT, with a simultaneous received byte that must be ignored.
    send("M", 1'b1, "M");
    send("N", 1'b1, "N");
    send(8'h0D, 1'b1, 8'h0D);
    wait_start(20, n, found);
    check("ab_start", {31'd0, found}, 32'd1);
    tick;
    abort = 1'b1; rx_dv = 1'b1; rx_byte = "Q";
    tick;
    abort = 1'b0; rx_dv = 1'b0; rx_byte = 8'h00;
    check("ab_echo", {31'd0, echo_dv}, 32'd0);
    check("ab_busy", {31'd0, busy}, 32'd0);
    check("ab_count", {29'd0, count}, 32'd0);
    check("ab_ovf", {31'd0, overflow}, 32'd0);
    pulse_done;
    wait_start(20, n, found);
    check("ab_no_start", {31'd0, found}, 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/morse_msg_sequencer.md
Name: morse_msg_sequencer

Overview:
- Parametrised successor to the single-shot Morse message controller.
- Buffers UART bytes in a circular FIFO and commits a message on CR (0x0D). Plays committed characters out one at a time over a start/done handshake to the Morse signal generator, inserting letter and word gaps measured in runtime-programmable units.
- Adds over the previous generation: concurrent receive during playback, backspace editing, overflow detection, and pointer wrap-around.

Parameters:
- DEPTH, 256: buffer entries; power of two, 4 or more.
- UNIT_W, 32: width of the i_Unit_Cycles input.
- LETTER_GAP_UNITS, 2: units waited after each non-space character.
- WORD_GAP_UNITS, 7: units waited for each space character.

Ports:
- i_Clk  in  1  system clock
- i_Rst  in  1  synchronous reset, active-high
- i_Unit_Cycles  in  UNIT_W  clock cycles per Morse unit; 0 is treated as 1
- i_RX_DV  in  1  one-cycle strobe, i_RX_Byte valid
- i_RX_Byte  in  8  received byte
- o_Echo_DV  out  1  one-cycle echo strobe to UART TX
- o_Echo_Byte  out  8  echo byte
- o_Char_Start  out  1  one-cycle start pulse to the signal generator
- o_Char  out  8  character being played; stable from START until the next FETCH
- i_Char_Done  in  1  generator done pulse
- o_Busy  out  1  high whenever state != IDLE
- o_Overflow  out  1  sticky; a byte was dropped because the buffer was full
- o_Count  out  $clog2(DEPTH)+1  occupancy, wr - rd

Behaviour:
- Reset (i_Rst high at a clock edge):
  - Pointers wr, cm (commit) and rd cleared to 0; state = IDLE.
  - All outputs 0.
  - Applies mid-operation too: playback stops immediately and the buffer empties.
- Pointers are $clog2(DEPTH)+1 bits and wrap modulo 2*DEPTH.
  - Full: wr - rd == DEPTH.
  - Storage index: pointer[$clog2(DEPTH)-1:0].
- Receive path, always active including during playback. On i_RX_DV:
  - CR (0x0D): cm <= wr. Echo 0x0D. Always accepted; CR takes no storage.
  - Backspace (0x08 or 0x7F):
    - If wr != cm: wr <= wr-1, echo 0x08.
    - Else: ignored, no echo.
  - Any other byte:
    - If not full: store at wr, wr <= wr+1, echo the byte.
    - If full: drop the byte, no echo, o_Overflow <= 1.
- Echo: o_Echo_DV and o_Echo_Byte are registered and appear in the cycle after i_RX_DV.
- Playback FSM:
  - IDLE: if rd != cm, go to FETCH.
  - FETCH:
    - Latch o_Char <= buf[rd]. The buffer read is combinational.
    - If the byte is 0x20 (space): load gap = WORD_GAP_UNITS and go to GAP.
    - Otherwise go to START.
  - START: o_Char_Start = 1 for exactly one cycle, then go to WAIT.
  - WAIT: on i_Char_Done, load gap = LETTER_GAP_UNITS and go to GAP. i_Char_Done is ignored in every other state.
  - GAP:
    - Latch U = max(i_Unit_Cycles, 1) on entry.
    - Remain exactly gap*U cycles.
    - Then rd <= rd+1 and go to IDLE.
- Latency: if CR is sampled at cycle T with rd == cm, o_Char_Start is high at T+3.
- Simultaneous events:
  - A receive write and an rd increment in the same cycle both take effect.
  - o_Count reflects both updates on the next cycle.
- Characters stored after a CR are held until the next CR; playback never passes cm.

Optional Feature:
- Macro: MORSE_ABORT_EN.
- Defined:
  - Adds port i_Abort (in, 1).
  - When i_Abort is high: rd <= wr, cm <= wr, state <= IDLE, and any pending o_Char_Start is suppressed.
  - i_Abort has priority over i_RX_DV in the same cycle.
  - o_Overflow is unaffected.
- Undefined: the port is absent and the behaviour is as above.

Test Plan:
- Basic playback, i_Unit_Cycles=4: send "SOS", then CR.
  - Three echoes.
  - o_Char_Start at T+3 with o_Char=0x53.
  - After i_Char_Done, the next start comes 8 cycles plus 2 FSM cycles later.
  - o_Busy falls after the third gap.
- Word gap: send "E E", then CR, U=4.
  - Space holds GAP for exactly 28 cycles.
  - No o_Char_Start is issued for the space.
- Backspace: send "AB", 0x08, "C", CR.
  - Echoes A, B, 08, C, 0D.
  - Playback is 'A' then 'C'.
  - Backspace with wr == cm produces no echo.
- Overflow at DEPTH=4: send 5 letters without CR.
  - 4 echoes; o_Count=4; o_Overflow=1.
  - After CR, plays 4 characters.
- Concurrent receive and wrap-around at DEPTH=4, U=1:
  - Commit a 3-character message.
  - During playback, send 3 more characters and a CR.
  - All 6 play in order; pointers wrap; no overflow.
- Reset mid-WAIT, and i_Abort under MORSE_ABORT_EN:
  - Outputs go to 0, o_Count=0, state IDLE.
  - No further o_Char_Start.
